div_unit: RTL and testbench

Iterative radix-2 divider for the RV64M divide/remainder instructions (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It sits beside the ALU in the execute stage and consumes the same operand buses: rs1 data as dividend, and the ALU operand-2 mux output as divisor. The single-cycle core holds the PC and suppresses register write-back while `busy` is high. It writes back `result` in the cycle `done` is high.

---
 rtl/div_unit_if.sv | 35 +++
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
//   master : core side; drives start, opcode flags, operands and flush; observes status/result.
//   slave  : divider side.
// Signals:
//   start, flush            request / abort
//   is_signed, is_rem,      opcode flags (DIV/REM/U/W variants)
//   is_word
//   dividend, divisor       rs1 value and operand-2 mux output
//   ready, busy, done       idle / stall request / one-cycle completion pulse
//   result                  quotient or remainder
interface div_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            start;
  logic            is_signed;
  logic            is_rem;
  logic            is_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, is_signed, is_rem, is_word, dividend, divisor, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, is_signed, is_rem, is_word, dividend, divisor, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV64M divide/remainder instructions.
// One quotient bit per cycle: 64 steps for full-width, 32 for W variants. Divide-by-zero and
// signed overflow bypass the iteration and complete one cycle after acceptance.
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset
//   bus  div_unit_if slave: start/flags/operands/flush in; ready/busy/done/result out
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int unsigned WordW = 32;
  localparam int unsigned CntW  = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              is_word_q, is_word_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand formation at acceptance
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val;
  logic            neg_a, neg_b, div_zero, overflow;

  always_comb begin
    if (bus.is_word) begin
      a_ext = bus.is_signed ? {{(XLEN-WordW){bus.dividend[WordW-1]}}, bus.dividend[WordW-1:0]}
                            : {{(XLEN-WordW){1'b0}}, bus.dividend[WordW-1:0]};
      b_ext = bus.is_signed ? {{(XLEN-WordW){bus.divisor[WordW-1]}}, bus.divisor[WordW-1:0]}
                            : {{(XLEN-WordW){1'b0}}, bus.divisor[WordW-1:0]};
      min_val = {{(XLEN-WordW+1){1'b1}}, {(WordW-1){1'b0}}};
    end else begin
      a_ext   = bus.dividend;
      b_ext   = bus.divisor;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg_a    = bus.is_signed & a_ext[XLEN-1];
    neg_b    = bus.is_signed & b_ext[XLEN-1];
    mag_a    = neg_a ? -a_ext : a_ext;
    mag_b    = neg_b ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = bus.is_signed && (a_ext == min_val) && (&b_ext);
  end

  // One restoring step; rem_q[XLEN] is always 0 so trial's MSB is a clean sign bit
  logic [XLEN+1:0] shifted, trial;
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {2'b00, div_q};
  end

  // Sign fixup and final selection, used in the DONE cycle
  logic [XLEN-1:0] q_fix, r_fix, sel, fin;
  always_comb begin
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    sel   = is_rem_q ? r_fix : q_fix;
    fin   = is_word_q ? {{(XLEN-WordW){sel[WordW-1]}}, sel[WordW-1:0]} : sel;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          is_rem_d  = bus.is_rem;
          is_word_d = bus.is_word;
          div_d     = mag_b;
          if (div_zero) begin
            quo_d     = '1;
            rem_d     = {1'b0, a_ext};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = StDone;
          end else if (overflow) begin
            quo_d     = a_ext;
            rem_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = StDone;
          end else begin
            // W operands sit in the upper half so 32 shifts consume exactly them
            quo_d     = bus.is_word ? (mag_a << WordW) : mag_a;
            rem_d     = '0;
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            cnt_d     = bus.is_word ? CntW'(WordW) : CntW'(XLEN);
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        if (!trial[XLEN+1]) begin
          rem_d = trial[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_d = fin;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      result_q  <= result_d;
    end
  end

  // result shows the new value during the DONE cycle and is held by result_q afterwards
  always_comb begin
    bus.ready  = (state_q == StIdle);
    bus.busy   = (state_q == StCalc) || ((state_q == StIdle) && bus.start);
    bus.done   = (state_q == StDone);
    bus.result = (state_q == StDone) ? fin : result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(64)) bus ();
  div_unit #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RISC-V M-extension semantics computed with plain arithmetic
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input bit s, input bit r, input bit w);
    logic [31:0]         q32, r32, s32;
    int                  sa32, sb32;
    logic [63:0]         q64, r64;
    longint              sa64, sb64;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a[31:0];
      end else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = 32'd0;
      end else if (s) begin
        q32 = sa32 / sb32; r32 = sa32 % sb32;
      end else begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
      end
      s32 = r ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    sa64 = a;
    sb64 = b;
    if (b == 64'd0) begin
      q64 = '1; r64 = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = '0;
    end else if (s) begin
      q64 = sa64 / sb64; r64 = sa64 % sb64;
    end else begin
      q64 = a / b; r64 = a % b;
    end
    return r ? r64 : q64;
  endfunction

  function automatic int unsigned latency(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input bit w);
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // Monitor: pop one expectation per done pulse; check result hold while idle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check64("result", bus.result, mon_e.res);
          check64("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          last_res = mon_e.res;
        end
      end else if (bus.ready === 1'b1) begin
        check64("result_hold", bus.result, last_res);
      end
    end
  end

  // Call at posedge+#1. Returns at posedge+#1 of cycle t0+1.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit s, input bit r,
                       input bit w, input bit push, input logic [63:0] res,
                       input int unsigned lat, output int unsigned t0);
    exp_t e;
    int   n = 0;
    while (bus.ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 300 cycles", bus.ready);
    end
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.is_rem    = r;
    bus.is_word   = w;
    bus.start     = 1'b1;
    t0 = cyc;
    if (push) begin
      e.res = res;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check64("busy_cycle0", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {32'($urandom), 32'h8000_0000};
      4:       return 64'($urandom_range(1, 20));
      5:       return -64'($urandom_range(1, 20));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  int unsigned t0;
  logic [63:0] ra, rb;
  bit          rs, rr, rw;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.is_signed = 1'b0;
    bus.is_rem    = 1'b0;
    bus.is_word   = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check64("reset_ready", 64'(bus.ready), 64'd1);
    check64("reset_busy", 64'(bus.busy), 64'd0);
    check64("reset_done", 64'(bus.done), 64'd0);
    check64("reset_result", bus.result, 64'd0);
    @(posedge clk); #1;

    // Directed cases with hand-derived results
    issue(64'd100, 64'd7, 0, 0, 0, 1, 64'd14, 65, t0);
    issue(64'd100, 64'd7, 0, 1, 0, 1, 64'd2, 65, t0);
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 65, t0);
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65, t0);
    issue(64'h1234, 64'd0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, t0);
    issue(64'h1234, 64'd0, 0, 1, 0, 1, 64'h1234, 1, t0);
    issue(64'h0000_0000_8000_0000, '1, 1, 0, 1, 1, 64'hFFFF_FFFF_8000_0000, 1, t0);
    issue(64'h8000_0000_0000_0000, '1, 1, 0, 0, 1, 64'h8000_0000_0000_0000, 1, t0);
    issue(64'h8000_0000_0000_0000, '1, 1, 1, 0, 1, 64'd0, 1, t0);
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, t0);
    drain();

    // Second start during CALC is ignored
    issue(64'd100, 64'd7, 0, 0, 0, 1, 64'd14, 65, t0);
    wait_until(t0 + 10);
    bus.dividend = 64'd555;
    bus.divisor  = 64'd3;
    bus.is_rem   = 1'b1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();

    // Flush at cycle 20: back to IDLE, no done, result kept
    issue(64'd1000, 64'd3, 0, 0, 0, 0, '0, 0, t0);
    wait_until(t0 + 20);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check64("flush_ready", 64'(bus.ready), 64'd1);
    check64("flush_busy", 64'(bus.busy), 64'd0);
    check64("flush_result", bus.result, 64'd14);
    repeat (80) @(posedge clk);
    #1;

    // Reset at cycle 30: reset values in cycle 31
    issue(64'd999, 64'd5, 0, 0, 0, 0, '0, 0, t0);
    wait_until(t0 + 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    last_res = '0;
    @(negedge clk);
    check64("rst_ready", 64'(bus.ready), 64'd1);
    check64("rst_busy", 64'(bus.busy), 64'd0);
    check64("rst_done", 64'(bus.done), 64'd0);
    check64("rst_result", bus.result, 64'd0);
    repeat (80) @(posedge clk);
    #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      rs = 1'($urandom);
      rr = 1'($urandom);
      rw = 1'($urandom);
      issue(ra, rb, rs, rr, rw, 1, model(ra, rb, rs, rr, rw), latency(ra, rb, rs, rw), t0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
